// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline control sequencer and the hazard unit.
// The interrupt sequence state is carried directly on the 2-bit count.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    CNT_IDLE    = 2'd0,
    CNT_VECTOR  = 2'd1,
    CNT_PUSH_PC = 2'd2,
    CNT_DRAIN   = 2'd3
  } cnt_e;

  localparam int          PC_W_DEF     = 32;
  localparam logic [31:0] VEC_ADDR_DEF = 32'h0000_0000;

  // Hazard unit stalls the front end while the sequence is in DRAIN or PUSH_PC.
  function automatic logic cnt_holds_front(input logic [1:0] cnt);
    return cnt > 2'd1;
  endfunction

endpackage

// File: rtl/int_edge_latch.sv
// Rising-edge detector on the interrupt line with a single-entry pending latch.
// Extra edges while a request is pending or in service collapse into one.
module int_edge_latch (
  input  logic clk,
  input  logic rst_n,
  input  logic int_req,
  input  logic accept,
  output logic pend
);

  logic int_q;
  logic rise;

  assign rise = int_req & ~int_q;

  // A new edge on the accept cycle keeps pend set so it is serviced next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_q <= 1'b0;
      pend  <= 1'b0;
    end else begin
      int_q <= int_req;
      pend  <= rise | (pend & ~accept);
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control sequencer: maps hazard stall/flush onto buffer strobes
// and runs the interrupt entry sequence DRAIN -> PUSH_PC -> VECTOR.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEF,
  parameter logic [PC_W-1:0] VEC_ADDR = PC_W'(VEC_ADDR_DEF)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            int_req,
  input  logic            stall,
  input  logic            flush,
  input  logic [PC_W-1:0] pc_ifid,
  output logic [1:0]      count,
  output logic            pc_en,
  output logic            pc_vec_sel,
  output logic [PC_W-1:0] vec_pc,
  output logic            ifid_en,
  output logic            ifid_flush,
  output logic            idex_flush,
  output logic            push_pc,
  output logic            push_flags,
  output logic [PC_W-1:0] epc,
  output logic            int_ack
);

  cnt_e state, state_n;
  logic pend;
  logic accept;

  // A flush or stall in IDLE defers entry so epc sees a settled IF/ID PC.
  assign accept = (state == CNT_IDLE) & pend & ~stall & ~flush;

  int_edge_latch u_edge (
    .clk     (clk),
    .rst_n   (rst),
    .int_req (int_req),
    .accept  (accept),
    .pend    (pend)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= CNT_IDLE;
      epc   <= '0;
    end else begin
      state <= state_n;
      if (accept) epc <= pc_ifid;
    end
  end

  always_comb begin
    state_n    = state;
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    push_pc    = 1'b0;
    push_flags = 1'b0;
    pc_vec_sel = 1'b0;
    int_ack    = 1'b0;
    case (state)
      CNT_IDLE: begin
        pc_en      = ~stall;
        ifid_en    = ~stall;
        ifid_flush = flush;
        idex_flush = stall | flush;
        if (accept) state_n = CNT_DRAIN;
      end
      CNT_DRAIN: begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
        state_n    = CNT_PUSH_PC;
      end
      CNT_PUSH_PC: begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
        push_pc    = 1'b1;
        state_n    = CNT_VECTOR;
      end
      CNT_VECTOR: begin
        // Redirect fetch to the vector and squash whatever was fetched meanwhile.
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        push_flags = 1'b1;
        pc_vec_sel = 1'b1;
        int_ack    = 1'b1;
        state_n    = CNT_IDLE;
      end
      default: state_n = CNT_IDLE;
    endcase
  end

  assign count  = state;
  assign vec_pc = VEC_ADDR;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: vector table, directed corner sequences,
// then random traffic against a cycle-level reference model.
module tb_pipe_ctrl;

  localparam int          PC_W = 32;
  localparam logic [31:0] VEC  = 32'h0000_0100;

  logic        clk = 1'b0, rst = 1'b0;
  logic        int_req = 1'b0, stall = 1'b0, flush = 1'b0;
  logic [31:0] pc_ifid = '0;
  logic [1:0]  count;
  logic        pc_en, pc_vec_sel, ifid_en, ifid_flush, idex_flush;
  logic        push_pc, push_flags, int_ack;
  logic [31:0] vec_pc, epc;
  logic [7:0]  ctrl;

  int n_run = 0, n_fail = 0, acks = 0;

  // Reference model: phase = cycles spent inside the interrupt sequence.
  int          m_phase = 0;
  bit          m_pend = 0, m_prev = 0;
  logic [31:0] m_epc = '0;

  always #5 clk = ~clk;

  pipe_ctrl #(.PC_W(PC_W), .VEC_ADDR(VEC)) dut (
    .clk(clk), .rst(rst), .int_req(int_req), .stall(stall), .flush(flush),
    .pc_ifid(pc_ifid), .count(count), .pc_en(pc_en), .pc_vec_sel(pc_vec_sel),
    .vec_pc(vec_pc), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .push_pc(push_pc), .push_flags(push_flags),
    .epc(epc), .int_ack(int_ack)
  );

  assign ctrl = {pc_en, ifid_en, ifid_flush, idex_flush,
                 push_pc, push_flags, pc_vec_sel, int_ack};

  typedef struct {
    logic        r, s, f;
    logic [31:0] pc;
    logic [1:0]  cnt;
    logic [7:0]  ctl;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_ctrl(input logic s, input logic f);
    case (m_phase)
      0:       return {~s, ~s, f, s | f, 4'b0000};
      1:       return 8'b0001_0000;
      2:       return 8'b0001_1000;
      default: return 8'b1111_0111;
    endcase
  endfunction

  function automatic logic [1:0] model_cnt();
    return (m_phase == 0) ? 2'd0 : 2'(4 - m_phase);
  endfunction

  task automatic model_reset();
    m_phase = 0; m_pend = 0; m_prev = 0; m_epc = '0;
  endtask

  task automatic model_clock(input logic r, input logic s, input logic f, input logic [31:0] pc);
    bit acc;
    acc = (m_phase == 0) && m_pend && !s && !f;
    if (acc) m_epc = pc;
    if (m_phase == 0) m_phase = acc ? 1 : 0;
    else              m_phase = (m_phase == 3) ? 0 : m_phase + 1;
    m_pend = (r && !m_prev) || (m_pend && !acc);
    m_prev = r;
  endtask

  // Starts and ends on a falling edge; samples 2 time units later.
  task automatic cycle(input logic r, input logic s, input logic f, input logic [31:0] pc);
    logic [7:0] msk;
    int_req = r; stall = s; flush = f; pc_ifid = pc;
    #2;
    msk = (m_phase == 3) ? 8'hBF : 8'hFF;
    chk("count", {30'b0, count}, {30'b0, model_cnt()});
    chk("ctrl", {24'b0, ctrl & msk}, {24'b0, model_ctrl(s, f) & msk});
    chk("epc", epc, m_epc);
    if (int_ack) acks++;
    @(posedge clk);
    model_clock(r, s, f, pc);
    @(negedge clk);
  endtask

  initial begin
    logic r;
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 32'h0,  2'd0, 8'b1100_0000};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 32'h0,  2'd0, 8'b0001_0000};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 32'h0,  2'd0, 8'b0001_0000};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,  2'd0, 8'b1100_0000};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 32'h0,  2'd0, 8'b1111_0000};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,  2'd0, 8'b1100_0000};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 32'h40, 2'd0, 8'b1100_0000};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 32'h40, 2'd0, 8'b1100_0000};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 32'h44, 2'd3, 8'b0001_0000};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 32'h48, 2'd2, 8'b0001_1000};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 32'h4c, 2'd1, 8'b1111_0111};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 32'h50, 2'd0, 8'b1100_0000};

    // Reset state
    @(negedge clk);
    chk("rst_count", {30'b0, count}, 32'd0);
    chk("rst_ctrl", {24'b0, ctrl}, 32'h0000_00C0);
    chk("rst_epc", epc, 32'd0);
    chk("vec_pc", vec_pc, VEC);
    rst = 1'b1;
    model_reset();

    // Vector table: stall, flush, then a full interrupt entry at pc 0x40
    for (int i = 0; i < 12; i++) begin
      int_req = tbl[i].r; stall = tbl[i].s; flush = tbl[i].f; pc_ifid = tbl[i].pc;
      #1;
      chk($sformatf("tbl%0d_count", i), {30'b0, count}, {30'b0, tbl[i].cnt});
      chk($sformatf("tbl%0d_ctrl", i), {24'b0, ctrl & ((tbl[i].cnt == 2'd1) ? 8'hBF : 8'hFF)},
          {24'b0, tbl[i].ctl & ((tbl[i].cnt == 2'd1) ? 8'hBF : 8'hFF)});
      cycle(tbl[i].r, tbl[i].s, tbl[i].f, tbl[i].pc);
    end
    chk("basic_epc", epc, 32'h40);
    chk("basic_acks", acks, 1);

    // Flush in the pending cycle defers entry; epc takes the later IF/ID PC
    cycle(1'b1, 1'b0, 1'b1, 32'h80);
    cycle(1'b1, 1'b0, 1'b1, 32'h80);
    chk("defer_flush_cnt", {30'b0, count}, 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 32'h200);
    chk("defer_flush_cnt3", {30'b0, count}, 32'd3);
    chk("defer_flush_epc", epc, 32'h200);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 32'h204);
    chk("defer_flush_idle", {30'b0, count}, 32'd0);

    // Stall for 3 cycles holds entry off
    cycle(1'b1, 1'b1, 1'b0, 32'h300);
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 32'h300);
      chk($sformatf("stall_hold%0d", i), {30'b0, count}, 32'd0);
    end
    cycle(1'b1, 1'b0, 1'b0, 32'h304);
    chk("stall_release", {30'b0, count}, 32'd3);
    chk("stall_epc", epc, 32'h304);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 32'h308);

    // Two edges during one sequence produce exactly one follow-on sequence
    acks = 0;
    cycle(1'b1, 1'b0, 1'b0, 32'h400);
    cycle(1'b0, 1'b0, 1'b0, 32'h400);
    cycle(1'b1, 1'b0, 1'b0, 32'h404);
    cycle(1'b0, 1'b0, 1'b0, 32'h408);
    cycle(1'b1, 1'b0, 1'b0, 32'h40c);
    chk("merge_idle_gap", {30'b0, count}, 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 32'h410);
    chk("merge_second", {30'b0, count}, 32'd3);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b0, 32'h414);
    chk("merge_done", {30'b0, count}, 32'd0);
    chk("merge_acks", acks, 2);

    // Reset mid-DRAIN with a second request already queued
    cycle(1'b1, 1'b1, 1'b0, 32'h500);
    cycle(1'b0, 1'b1, 1'b0, 32'h500);
    cycle(1'b1, 1'b0, 1'b0, 32'h504);
    chk("pre_rst_drain", {30'b0, count}, 32'd3);
    int_req = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_count", {30'b0, count}, 32'd0);
    chk("mid_rst_ctrl", {24'b0, ctrl}, 32'h0000_00C0);
    chk("mid_rst_epc", epc, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0, 32'h600);
    chk("rst_discard", {30'b0, count}, 32'd0);

    // Random traffic against the model
    r = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) r = ~r;
      cycle(r, ($urandom_range(0, 4) == 0), ($urandom_range(0, 6) == 0),
            $urandom() & 32'hFFFF_FFFC);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
